// File: rtl/alu_multicycle.sv
// alu_multicycle: WIDTH-bit ALU with start/ready/valid handshake; single-cycle ops plus iterative MUL/MULHU and DIVU/REMU
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start_i,
  input  logic [3:0]       ALU_Operation_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  output logic             Ready_o,
  output logic             Valid_o,
  output logic [WIDTH-1:0] ALU_Result_o,
  output logic             Zero_o,
  output logic             Carry_o,
  output logic             Overflow_o,
  output logic             DivZero_o
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_nx;
  logic [SHW-1:0] cnt, shamt;
  logic [2*WIDTH-1:0] acc, acc_nx;
  logic [WIDTH-1:0] opb, res, iter_res;
  logic [WIDTH:0] sum, dif, step, trial;
  logic hi_q, carry, ovf, accept, multi, div_op, div0, busy, last, bneg_msb;
  assign shamt = B_i[SHW-1:0];
  assign sum = {1'b0, A_i} + {1'b0, B_i};
  assign dif = {1'b0, A_i} - {1'b0, B_i};
  // sign bit of the two's-complement negation of B
  assign bneg_msb = (B_i != '0) && (!B_i[WIDTH-1] || B_i[WIDTH-2:0] == '0);
  assign accept = Start_i && state == IDLE;
  assign multi = ALU_Operation_i[3:2] == 2'b11;
  assign div_op = ALU_Operation_i[3:1] == 3'b111;
  assign div0 = div_op && B_i == '0;
  assign busy = state == MUL || state == DIV;
  assign last = cnt == SHW'(WIDTH - 1);
  always_comb begin
    res = '0;
    carry = 1'b0;
    ovf = 1'b0;
    case (ALU_Operation_i)
      4'h0: begin
        res = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf = (A_i[WIDTH-1] == B_i[WIDTH-1]) && (sum[WIDTH-1] != A_i[WIDTH-1]);
      end
      4'h1: begin
        res = dif[WIDTH-1:0];
        carry = dif[WIDTH];
        ovf = (A_i[WIDTH-1] == bneg_msb) && (dif[WIDTH-1] != A_i[WIDTH-1]);
      end
      4'h2: res = A_i & B_i;
      4'h3: res = A_i | B_i;
      4'h4: res = A_i ^ B_i;
      4'h5: res = ~A_i;
      4'h6: res = A_i << shamt;
      4'h7: res = A_i >> shamt;
      4'h8: res = $signed(A_i) >>> shamt;
      4'h9: res = {B_i[WIDTH-13:0], 12'h000};
      4'hA: res = WIDTH'($signed(A_i) < $signed(B_i));
      4'hB: res = WIDTH'(A_i < B_i);
      4'hE: res = '1;
      4'hF: res = A_i;
      default: res = '0;
    endcase
  end
  // one shift-add (MUL) or restoring-subtract (DIV) step on the {hi, lo} accumulator
  assign step = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb & {WIDTH{acc[0]}}};
  assign trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb};
  assign acc_nx = state == MUL ? {step, acc[WIDTH-1:1]}
                : trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  assign iter_res = hi_q ? acc_nx[2*WIDTH-1:WIDTH] : acc_nx[WIDTH-1:0];
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (Start_i) state_nx = !multi || div0 ? DONE : div_op ? DIV : MUL;
      MUL, DIV: if (last) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      opb <= '0;
      hi_q <= 1'b0;
      ALU_Result_o <= '0;
      Zero_o <= 1'b1;
      Carry_o <= 1'b0;
      Overflow_o <= 1'b0;
      DivZero_o <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt <= '0;
        opb <= B_i;
        hi_q <= ALU_Operation_i[0];
        acc <= {{WIDTH{1'b0}}, A_i};
      end else if (busy) begin
        cnt <= cnt + 1'b1;
        acc <= acc_nx;
      end
      if (accept && (!multi || div0)) begin
        ALU_Result_o <= res;
        Zero_o <= res == '0;
        Carry_o <= carry;
        Overflow_o <= ovf;
        DivZero_o <= div0;
      end else if (busy && last) begin
        ALU_Result_o <= iter_res;
        Zero_o <= iter_res == '0;
        Carry_o <= 1'b0;
        Overflow_o <= 1'b0;
        DivZero_o <= 1'b0;
      end
    end
  end
  assign Ready_o = state == IDLE;
  assign Valid_o = state == DONE;
endmodule
